// File: rtl/tetromino_randomizer.sv
// NES-style tetromino picker: biases the LFSR roll by spawn count and rerolls
// once on a 7 or a repeat, keeping a current piece plus a next-piece preview.
module tetromino_randomizer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rand_data,
  input  logic             req,
  output logic [2:0]       piece_cur,
  output logic [2:0]       piece_next,
  output logic             valid,
  output logic [CNT_W-1:0] spawn_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROLL   = 2'd1;
  localparam logic [1:0] REROLL = 2'd2;

  logic [1:0] state;
  logic [1:0] prime_cnt;

  logic [2:0] cand;
  logic [3:0] sum;
  logic [3:0] sum_wrapped;
  logic [2:0] reroll_id;
  logic [1:0] prime_dec;
  logic       do_commit;
  logic [2:0] commit_id;

  // Candidate IDs for both roll flavours; the reroll sum folds 7..13 back to 0..6.
  always_comb begin
    cand        = rand_data[2:0] + spawn_count[2:0];
    sum         = {1'b0, rand_data[2:0]} + {1'b0, piece_next};
    sum_wrapped = sum - 4'd7;
    reroll_id   = (sum >= 4'd7) ? sum_wrapped[2:0] : sum[2:0];
    prime_dec   = (prime_cnt != 2'd0) ? prime_cnt - 2'd1 : 2'd0;
    do_commit   = 1'b0;
    commit_id   = cand;
    case (state)
      ROLL:    do_commit = (cand != 3'd7) && (cand != piece_next);
      REROLL: begin
        do_commit = 1'b1;
        commit_id = reroll_id;
      end
      default: do_commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      piece_cur   <= 3'd0;
      piece_next  <= 3'd0;
      valid       <= 1'b0;
      spawn_count <= '0;
      state       <= ROLL;
      prime_cnt   <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= ROLL;
            valid <= 1'b0;
          end
        end
        ROLL: begin
          if (!do_commit) state <= REROLL;
        end
        REROLL: ;
        default: begin
          state <= ROLL;
          valid <= 1'b0;
        end
      endcase

      // A commit shifts the preview into the current slot; priming keeps rolling.
      if (do_commit) begin
        piece_cur   <= piece_next;
        piece_next  <= commit_id;
        spawn_count <= spawn_count + CNT_W'(1);
        prime_cnt   <= prime_dec;
        if (prime_dec != 2'd0) begin
          state <= ROLL;
          valid <= 1'b0;
        end else begin
          state <= IDLE;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tetromino_randomizer.md
Name: tetromino_randomizer

Overview:
- Consumes the 5-bit pseudo-random word from the game's LFSR and turns it into tetromino IDs (0..6) using NES-style rules: bias by spawn count, and reroll on an invalid or repeated pick.
- Keeps a current piece and a next-piece preview for the game FSM.
- Generates on request through a small state machine.

Parameters:
- CNT_W, 8, width of the spawn counter. Must be ≥3; the low 3 bits bias the roll.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rand_data  in  5  LFSR output; advances every clk; only bits [2:0] are used
- req  in  1  game FSM requests a new piece; sampled only while valid=1
- piece_cur  out  3  piece to spawn now
- piece_next  out  3  preview piece; also "prev" for the repeat check
- valid  out  1  piece_cur/piece_next stable and req will be accepted
- spawn_count  out  CNT_W  number of committed generations, including priming

Behaviour:
- One clock; reset is synchronous and active-high, sampled at posedge clk; it overrides everything else.
- Reset values:
  - piece_cur=0, piece_next=0, valid=0, spawn_count=0.
  - State=ROLL, prime counter=2.
- States: IDLE, ROLL, REROLL.
- Generation = commit of a new ID n:
  - piece_cur<=piece_next, piece_next<=n.
  - spawn_count<=spawn_count+1, wrapping modulo 2^CNT_W.
- ROLL, on each edge:
  - cand = (rand_data[2:0] + spawn_count[2:0]) mod 8, 3-bit wrap.
  - If cand!=7 and cand!=piece_next: commit cand.
  - Else: go to REROLL, with no register changes except state.
- REROLL, on each edge:
  - s = rand_data[2:0] + piece_next, evaluated 4 bits wide (0..13).
  - n = s>=7 ? s-7 : s.
  - Commit n unconditionally; a repeat of piece_next is allowed here.
- After a commit:
  - If prime counter>0 after decrement, go to ROLL with valid=0.
  - Else go to IDLE with valid=1.
- Priming: the first two generations after reset run automatically. valid rises only after the second commit.
- IDLE:
  - valid=1.
  - If req=1 at the edge: state<=ROLL, valid<=0, no other changes.
  - If req=0: hold.
- Latency from the req edge (k):
  - Accepted roll: new pieces and valid=1 at edge k+1.
  - Reroll: new pieces and valid=1 at edge k+2.
  - valid is low for 1 or 2 cycles.
- req with valid=0 (ROLL/REROLL/priming) is ignored, not queued.
- req held high continuously starts a new generation on every cycle valid is 1.
- rand_data is sampled freshly in each ROLL/REROLL cycle. Because the LFSR advances every clk, the REROLL value differs from the ROLL value.
- Reset mid-operation, including during REROLL or with req high: next edge gives the reset values and priming restarts. No partial commit.
- Outputs are registered only; no combinational path from rand_data or req to any output.

Test Plan:
- Priming: release reset, rand_data=3 constant.
  - Edge 1: cand 3≠0 → piece_next=3, count=1, valid=0.
  - Edge 2: cand 4≠3 → piece_cur=3, piece_next=4, count=2, valid=1.
- Accepted roll: from cur=3, next=4, count=2, pulse req, then rand_data=1 at ROLL.
  - cand=3 → cur=4, next=3, count=3.
  - valid low exactly 1 cycle.
- Reroll on 7: from next=4, count=2, req.
  - ROLL rand=5 → cand 7 → REROLL.
  - REROLL rand=6 → (6+4)=10→3.
  - Result: cur=4, next=3, count=3, valid low 2 cycles.
- Reroll on repeat: from next=4, count=2, req.
  - ROLL rand=2 → cand 4=prev → REROLL.
  - REROLL rand=0 → n=4.
  - Result: cur=4, next=4 (repeat permitted).
- Ignored/held req, then wrap:
  - Pulse req while valid=0 → no extra generation.
  - Hold req high 10 cycles with accepting rand → a generation every 2 cycles.
  - Preload count=255 (run generations) → next commit gives spawn_count=0.
- Reset mid-REROLL: assert reset in the REROLL cycle.
  - Next edge: cur=0, next=0, valid=0, count=0.
  - After deassert: priming repeats, valid=1 after two more edges.
